// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and BHT counter type for the IF stage
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_t;

  function automatic bht_t bht_next(input bht_t cur, input logic taken);
    bht_t nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// rtl/fetch_stage_branch_predictor.sv - direct-mapped 2-bit BHT plus BTB
// Lookup is combinational on the fetch PC; the update port writes at the clock edge.
module branch_predictor
  import fetch_stage_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lk_pc,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << BHT_IDX_W;
  localparam int TAG_W   = 32 - BHT_IDX_W - 2;

  bht_t             bht_q        [ENTRIES];
  bht_t             bht_d        [ENTRIES];
  logic             btb_valid_q  [ENTRIES];
  logic             btb_valid_d  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0] btb_tag_d    [ENTRIES];
  logic [31:0]      btb_target_q [ENTRIES];
  logic [31:0]      btb_target_d [ENTRIES];

  logic [BHT_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 unused_align;

  assign lk_idx       = lk_pc[BHT_IDX_W+1:2];
  assign lk_tag       = lk_pc[31:BHT_IDX_W+2];
  assign upd_idx      = upd_pc[BHT_IDX_W+1:2];
  assign upd_tag      = upd_pc[31:BHT_IDX_W+2];
  assign unused_align = ^{lk_pc[1:0], upd_pc[1:0]};

  // Reads come from the _q arrays, so a same-cycle update is not visible yet.
  assign lk_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && bht_q[lk_idx][1];
  assign lk_target = btb_target_q[lk_idx];

  always_comb begin
    bht_d        = bht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid) begin
      bht_d[upd_idx] = bht_next(bht_q[upd_idx], upd_taken);
      if (upd_taken) begin
        btb_valid_d[upd_idx]  = 1'b1;
        btb_tag_d[upd_idx]    = upd_tag;
        btb_target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i]        <= WNT;
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else begin
      bht_q        <= bht_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC mux and IF/ID register
// Priority for both PC and IF/ID: flush, then stall, then prediction/sequential.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_target
);

  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_pred_taken_q, ifid_pred_taken_d;
  logic [31:0] ifid_pred_target_q, ifid_pred_target_d;
  logic        pred_taken;
  logic [31:0] pred_target;

  branch_predictor #(.BHT_IDX_W(BHT_IDX_W)) u_bp (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (pc_q),
    .lk_taken   (pred_taken),
    .lk_target  (pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  always_comb begin
    pc_d               = pc_q;
    ifid_valid_d       = ifid_valid_q;
    ifid_pc_d          = ifid_pc_q;
    ifid_instr_d       = ifid_instr_q;
    ifid_pred_taken_d  = ifid_pred_taken_q;
    ifid_pred_target_d = ifid_pred_target_q;
    if (flush) begin
      pc_d              = redirect_pc;
      ifid_valid_d      = 1'b0;
      ifid_instr_d      = NOP_INSTR;
      ifid_pred_taken_d = 1'b0;
    end else if (!stall) begin
      pc_d               = pred_taken ? pred_target : pc_q + 32'd4;
      ifid_valid_d       = 1'b1;
      ifid_pc_d          = pc_q;
      ifid_instr_d       = imem_rdata;
      ifid_pred_taken_d  = pred_taken;
      ifid_pred_target_d = pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      ifid_valid_q       <= 1'b0;
      ifid_pc_q          <= '0;
      ifid_instr_q       <= NOP_INSTR;
      ifid_pred_taken_q  <= 1'b0;
      ifid_pred_target_q <= '0;
    end else begin
      pc_q               <= pc_d;
      ifid_valid_q       <= ifid_valid_d;
      ifid_pc_q          <= ifid_pc_d;
      ifid_instr_q       <= ifid_instr_d;
      ifid_pred_taken_q  <= ifid_pred_taken_d;
      ifid_pred_target_q <= ifid_pred_target_d;
    end
  end

  assign imem_addr        = pc_q;
  assign ifid_valid       = ifid_valid_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instr       = ifid_instr_q;
  assign ifid_pred_taken  = ifid_pred_taken_q;
  assign ifid_pred_target = ifid_pred_target_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_pred_taken;
  logic [31:0] ifid_pred_target;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Instruction memory: word derived from the address so IF/ID contents are traceable.
  assign imem_rdata = imem_addr ^ SALT;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .ifid_valid       (ifid_valid),
    .ifid_pc          (ifid_pc),
    .ifid_instr       (ifid_instr),
    .ifid_pred_taken  (ifid_pred_taken),
    .ifid_pred_target (ifid_pred_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] pc);
    flush = 1'b1;
    redirect_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic train(input logic taken, input int times);
    for (int i = 0; i < times; i++) begin
      upd_valid  = 1'b1;
      upd_pc     = 32'h40;
      upd_taken  = taken;
      upd_target = 32'h80;
      tick();
    end
    upd_valid = 1'b0;
  endtask

  task automatic fetch_expect(input string tag, input logic [31:0] pc, input logic taken,
                              input logic [31:0] next_pc);
    goto_pc(pc);
    check({tag, "_pc"}, imem_addr, pc);
    tick();
    check({tag, "_pred"}, {31'd0, ifid_pred_taken}, {31'd0, taken});
    check({tag, "_next"}, imem_addr, next_pc);
    if (taken) check({tag, "_tgt"}, ifid_pred_target, next_pc);
  endtask

  initial begin
    #12;
    check("rst_pc",    imem_addr, 32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_ifpc",  ifid_pc, 32'h0);
    check("rst_pred",  {31'd0, ifid_pred_taken}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_pc", imem_addr, 32'h0);

    // Free run: pc = 4k, IF/ID lags one cycle.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("run_pc",    imem_addr, 32'(4 * k));
      check("run_ifpc",  ifid_pc, 32'(4 * (k - 1)));
      check("run_instr", ifid_instr, 32'(4 * (k - 1)) ^ SALT);
      check("run_valid", {31'd0, ifid_valid}, 32'h1);
      check("run_pred",  {31'd0, ifid_pred_taken}, 32'h0);
    end

    // Two stall cycles at pc=0x10.
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_pc",    imem_addr, 32'h10);
      check("stall_ifpc",  ifid_pc, 32'h0C);
      check("stall_instr", ifid_instr, 32'h0C ^ SALT);
    end
    stall = 1'b0;
    tick();
    check("resume_pc",   imem_addr, 32'h14);
    check("resume_ifpc", ifid_pc, 32'h10);

    // Flush wins over stall.
    stall = 1'b1;
    flush = 1'b1;
    redirect_pc = 32'h200;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    check("flush_pc",    imem_addr, 32'h200);
    check("flush_valid", {31'd0, ifid_valid}, 32'h0);
    check("flush_instr", ifid_instr, NOP);
    check("flush_pred",  {31'd0, ifid_pred_taken}, 32'h0);
    tick();
    check("after_flush_ifpc",  ifid_pc, 32'h200);
    check("after_flush_valid", {31'd0, ifid_valid}, 32'h1);
    check("after_flush_pc",    imem_addr, 32'h204);

    // Untrained: no prediction at 0x40.
    fetch_expect("cold", 32'h40, 1'b0, 32'h44);

    // WNT -> WT with BTB fill.
    train(1'b1, 1);
    fetch_expect("t1", 32'h40, 1'b1, 32'h80);
    check("t1_instr", ifid_instr, 32'h40 ^ SALT);
    train(1'b0, 1);
    fetch_expect("nt1", 32'h40, 1'b0, 32'h44);
    train(1'b0, 1);
    fetch_expect("nt2", 32'h40, 1'b0, 32'h44);

    // SNT + 5 taken saturates at ST; one not-taken leaves WT.
    train(1'b1, 5);
    train(1'b0, 1);
    fetch_expect("sat_hi", 32'h40, 1'b1, 32'h80);
    // 5 not-taken saturates at SNT; one taken gives WNT.
    train(1'b0, 5);
    train(1'b1, 1);
    fetch_expect("sat_lo", 32'h40, 1'b0, 32'h44);

    // Same-cycle update and lookup: lookup sees WNT, entry then becomes WT.
    goto_pc(32'h40);
    upd_valid  = 1'b1;
    upd_pc     = 32'h40;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    tick();
    upd_valid = 1'b0;
    check("rbw_pred", {31'd0, ifid_pred_taken}, 32'h0);
    check("rbw_next", imem_addr, 32'h44);
    fetch_expect("rbw_after", 32'h40, 1'b1, 32'h80);

    // Alias at same index, different tag.
    fetch_expect("alias", 32'h40 + (32'd4 << 6), 1'b0, 32'h144);

    // Sequential wrap.
    fetch_expect("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle clears pipeline and predictor.
    goto_pc(32'h300);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_pc",    imem_addr, 32'h0);
    check("arst_valid", {31'd0, ifid_valid}, 32'h0);
    check("arst_instr", ifid_instr, NOP);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_first_ifpc", ifid_pc, 32'h0);
    fetch_expect("arst_btb", 32'h40, 1'b0, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, limit 200000 expected completion");
    $fatal(1);
  end

endmodule
